// File: rtl/ddr5_request_queue.sv
// DDR5 scheduler front-end request queue.
// Admits trace requests once the CPU-cycle counter reaches their timestamp, decodes the
// physical address into DRAM coordinates at write time and presents the oldest entry.
module ddr5_request_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter bit          SKIP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_time,
    input  logic [3:0]  req_core,
    input  logic [1:0]  req_op,
    input  logic [33:0] req_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_time,
    output logic [3:0]  out_core,
    output logic [1:0]  out_op,
    output logic [15:0] out_row,
    output logic [9:0]  out_col,
    output logic [1:0]  out_bank,
    output logic [2:0]  out_bank_group,
    output logic        out_channel,
    output logic [63:0] cycle,
    output logic [$clog2(DEPTH):0] count,
    output logic        op_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [63:0] tstamp;
        logic [3:0]  core;
        logic [1:0]  op;
        logic [15:0] row;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [2:0]  bank_group;
        logic        channel;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic [63:0]   cycle_q, cycle_d, cycle_inc;
    logic          op_err_q;
    logic          accept, push, pop;
    logic          unused_byte_sel;

    // Byte select within the burst is not part of the DRAM coordinates.
    assign unused_byte_sel = ^req_addr[1:0];

    // Admission is combinational; reset holds it low even though state already reads idle.
    assign req_ready = !rst && (count_q < FULL) && (req_time <= cycle_q);
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_op != 2'd3);
    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != '0);
    assign cycle     = cycle_q;
    assign count     = count_q;
    assign op_err    = op_err_q;
    assign head      = mem[rd_ptr_q];

    // Decode the address into DRAM fields as the entry is written.
    always_comb begin
        wr_entry            = '0;
        wr_entry.tstamp     = req_time;
        wr_entry.core       = req_core;
        wr_entry.op         = req_op;
        wr_entry.row        = req_addr[33:18];
        wr_entry.col        = {req_addr[17:12], req_addr[5:2]};
        wr_entry.bank       = req_addr[11:10];
        wr_entry.bank_group = req_addr[9:7];
        wr_entry.channel    = req_addr[6];
    end

    // Next cycle count: free-running, jumping ahead over idle time when nothing is queued.
    always_comb begin
        cycle_inc = cycle_q + 64'd1;
        cycle_d   = cycle_inc;
        if (SKIP_EN && (count_q == '0) && req_valid && (req_time > cycle_inc)) begin
            cycle_d = req_time;
        end
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, occupancy, cycle counter and illegal-op pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cycle_q  <= '0;
            op_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            cycle_q  <= cycle_d;
            op_err_q <= accept && (req_op == 2'd3);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    // Head presentation, forced to zero whenever the queue is empty.
    always_comb begin
        out_time       = '0;
        out_core       = '0;
        out_op         = '0;
        out_row        = '0;
        out_col        = '0;
        out_bank       = '0;
        out_bank_group = '0;
        out_channel    = 1'b0;
        if (out_valid) begin
            out_time       = head.tstamp;
            out_core       = head.core;
            out_op         = head.op;
            out_row        = head.row;
            out_col        = head.col;
            out_bank       = head.bank;
            out_bank_group = head.bank_group;
            out_channel    = head.channel;
        end
    end

endmodule
